motion_update_broadcaster: RTL and testbench

Sequencer that drives the motion-update broadcast bus consumed by every position cache. It walks every cell in a fixed scan order. For each cell it reads the particle count from address 0, then reads each particle's position and displacement. It adds them to form the new position, derives the destination cell from the new position's high bits, and broadcasts `{data, dst_cell, valid}` while holding `motion_update_enable` high for the whole pass. It sits in the top level between the cell read ports and the per-cell position caches.

---
 rtl/motion_update_broadcaster.sv | 234 +++++++++++++++++++++++
 tb/tb_motion_update_broadcaster.sv | 353 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/motion_update_broadcaster.sv
// motion_update_broadcaster
//
// Walks every cell in z-fastest / y / x order and, for each cell, reads the
// particle count (address 0) and then every particle (addresses 1..count).
// For each particle it forms new = pos + disp per coordinate, with wrap-around.
// It derives the destination cell from the top CELL_ID_WIDTH bits of each
// coordinate and broadcasts the result to the position caches.
//
// Ports:
//   clk, rst               clock, asynchronous active-high reset
//   start                  one-cycle pulse that begins a pass (ignored while busy)
//   out_rd_cell            cell being read, {x,y,z}
//   out_rd_address         address within that cell (0 = count word)
//   out_rden               read enable
//   in_pos / in_disp       read data, {z,y,x}, one cycle after the address
//   motion_update_enable   high for the whole broadcast window
//   out_data               new position {z,y,x}
//   out_data_dst_cell      destination cell {x,y,z}
//   out_data_valid         broadcast qualifier
//   out_busy               pass in progress
//   out_done               one-cycle pulse at the end of a pass
//   out_error              sticky: a destination index was out of range
module motion_update_broadcaster #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDR_WIDTH    = 8,
  parameter int CELL_ID_WIDTH = 4,
  parameter int CELL_NUM_X    = 4,
  parameter int CELL_NUM_Y    = 4,
  parameter int CELL_NUM_Z    = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  output logic [3*CELL_ID_WIDTH-1:0] out_rd_cell,
  output logic [ADDR_WIDTH-1:0]      out_rd_address,
  output logic                       out_rden,
  input  logic [3*DATA_WIDTH-1:0]    in_pos,
  input  logic [3*DATA_WIDTH-1:0]    in_disp,
  output logic                       motion_update_enable,
  output logic [3*DATA_WIDTH-1:0]    out_data,
  output logic [3*CELL_ID_WIDTH-1:0] out_data_dst_cell,
  output logic                       out_data_valid,
  output logic                       out_busy,
  output logic                       out_done,
  output logic                       out_error
);

  typedef enum logic [2:0] {
    IDLE,
    READ_COUNT,
    WAIT_COUNT,
    STREAM,
    NEXT_CELL,
    DRAIN,
    HOLD
  } state_t;

  localparam logic [CELL_ID_WIDTH-1:0] LAST_X = CELL_ID_WIDTH'(CELL_NUM_X - 1);
  localparam logic [CELL_ID_WIDTH-1:0] LAST_Y = CELL_ID_WIDTH'(CELL_NUM_Y - 1);
  localparam logic [CELL_ID_WIDTH-1:0] LAST_Z = CELL_ID_WIDTH'(CELL_NUM_Z - 1);

  state_t                   state_reg, state_next;
  logic [ADDR_WIDTH-1:0]    addr_reg, addr_next;
  logic [ADDR_WIDTH-1:0]    count_reg, count_next;
  logic [CELL_ID_WIDTH-1:0] cell_x_reg, cell_x_next;
  logic [CELL_ID_WIDTH-1:0] cell_y_reg, cell_y_next;
  logic [CELL_ID_WIDTH-1:0] cell_z_reg, cell_z_next;
  logic [1:0]               hold_cnt_reg, hold_cnt_next;
  logic                     enable_reg, enable_next;
  logic                     busy_reg, busy_next;
  logic                     done_reg, done_next;
  logic                     error_reg, error_next;

  // Broadcast pipeline: rd_pend_reg marks a particle read whose data is on
  // in_pos/in_disp this cycle; the output stage registers the result.
  logic                                  rd_pend_reg;
  logic                                  valid_reg;
  logic [2:0][DATA_WIDTH-1:0]            data_reg;
  logic [3*CELL_ID_WIDTH-1:0]            dst_reg;

  logic [2:0][DATA_WIDTH-1:0]            new_pos;
  logic [2:0][CELL_ID_WIDTH-1:0]         dst_idx;
  logic [2:0]                            in_range;
  logic                                  particle_ok;
  logic                                  particle_bad;

  // Per-dimension update: index 0 = x, 1 = y, 2 = z (x in the low bits).
  for (genvar gi = 0; gi < 3; gi++) begin : g_dim
    localparam int LIMIT = (gi == 0) ? CELL_NUM_X : (gi == 1) ? CELL_NUM_Y : CELL_NUM_Z;
    assign new_pos[gi]  = in_pos[gi*DATA_WIDTH +: DATA_WIDTH] + in_disp[gi*DATA_WIDTH +: DATA_WIDTH];
    assign dst_idx[gi]  = new_pos[gi][DATA_WIDTH-1 -: CELL_ID_WIDTH];
    assign in_range[gi] = ({1'b0, dst_idx[gi]} < (CELL_ID_WIDTH+1)'(LIMIT));
  end

  assign particle_ok  = rd_pend_reg & (&in_range);
  assign particle_bad = rd_pend_reg & ~(&in_range);

  // Next-state and control
  always_comb begin
    state_next    = state_reg;
    addr_next     = addr_reg;
    count_next    = count_reg;
    cell_x_next   = cell_x_reg;
    cell_y_next   = cell_y_reg;
    cell_z_next   = cell_z_reg;
    hold_cnt_next = hold_cnt_reg;
    enable_next   = enable_reg;
    busy_next     = busy_reg;
    done_next     = 1'b0;
    error_next    = error_reg | particle_bad;

    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next  = READ_COUNT;
          enable_next = 1'b1;
          busy_next   = 1'b1;
          error_next  = 1'b0;
        end
      end
      READ_COUNT: state_next = WAIT_COUNT;
      WAIT_COUNT: begin
        count_next = in_pos[ADDR_WIDTH-1:0];
        if (in_pos[ADDR_WIDTH-1:0] == '0) begin
          state_next = NEXT_CELL;
        end else begin
          state_next = STREAM;
          addr_next  = ADDR_WIDTH'(1);
        end
      end
      STREAM: begin
        if (addr_reg == count_reg) begin
          state_next = NEXT_CELL;
        end else begin
          addr_next = addr_reg + ADDR_WIDTH'(1);
        end
      end
      NEXT_CELL: begin
        // z fastest, then y, then x; counters wrap back to (0,0,0) after the last cell
        if (cell_z_reg == LAST_Z) begin
          cell_z_next = '0;
          if (cell_y_reg == LAST_Y) begin
            cell_y_next = '0;
            cell_x_next = (cell_x_reg == LAST_X) ? '0 : cell_x_reg + CELL_ID_WIDTH'(1);
          end else begin
            cell_y_next = cell_y_reg + CELL_ID_WIDTH'(1);
          end
        end else begin
          cell_z_next = cell_z_reg + CELL_ID_WIDTH'(1);
        end
        if (cell_x_reg == LAST_X && cell_y_reg == LAST_Y && cell_z_reg == LAST_Z) begin
          state_next = DRAIN;
        end else begin
          state_next = READ_COUNT;
        end
      end
      DRAIN: begin
        // Only the output stage can still be full here; it empties this
        // cycle, so enable drops the cycle after the last valid.
        if (!rd_pend_reg) begin
          state_next    = HOLD;
          enable_next   = 1'b0;
          hold_cnt_next = '0;
        end
      end
      HOLD: begin
        // Gives the caches time for their count-write and buffer swap.
        if (hold_cnt_reg == 2'd2) begin
          state_next = IDLE;
          done_next  = 1'b1;
          busy_next  = 1'b0;
        end else begin
          hold_cnt_next = hold_cnt_reg + 2'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      count_reg    <= '0;
      cell_x_reg   <= '0;
      cell_y_reg   <= '0;
      cell_z_reg   <= '0;
      hold_cnt_reg <= '0;
      enable_reg   <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      error_reg    <= 1'b0;
    end else begin
      state_reg    <= state_next;
      addr_reg     <= addr_next;
      count_reg    <= count_next;
      cell_x_reg   <= cell_x_next;
      cell_y_reg   <= cell_y_next;
      cell_z_reg   <= cell_z_next;
      hold_cnt_reg <= hold_cnt_next;
      enable_reg   <= enable_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
      error_reg    <= error_next;
    end
  end

  // Broadcast pipeline; the bus is forced to zero whenever it is not valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_pend_reg <= 1'b0;
      valid_reg   <= 1'b0;
      data_reg    <= '0;
      dst_reg     <= '0;
    end else begin
      rd_pend_reg <= (state_reg == STREAM);
      valid_reg   <= particle_ok;
      data_reg    <= particle_ok ? new_pos : '0;
      dst_reg     <= particle_ok ? {dst_idx[0], dst_idx[1], dst_idx[2]} : '0;
    end
  end

  assign out_rden             = (state_reg == READ_COUNT) || (state_reg == STREAM);
  assign out_rd_address       = (state_reg == STREAM) ? addr_reg : '0;
  assign out_rd_cell          = {cell_x_reg, cell_y_reg, cell_z_reg};
  assign motion_update_enable = enable_reg;
  assign out_data             = data_reg;
  assign out_data_dst_cell    = dst_reg;
  assign out_data_valid       = valid_reg;
  assign out_busy             = busy_reg;
  assign out_done             = done_reg;
  assign out_error            = error_reg;

endmodule

// File: tb/tb_motion_update_broadcaster.sv
module tb_motion_update_broadcaster;

  localparam int DW    = 32;
  localparam int AW    = 8;
  localparam int CIW   = 2;
  localparam int NX    = 3;
  localparam int NY    = 2;
  localparam int NZ    = 2;
  localparam int NCELL = NX * NY * NZ;
  localparam int MAXA  = 16;
  localparam int MAXC  = 1024;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [3*CIW-1:0]  out_rd_cell;
  logic [AW-1:0]     out_rd_address;
  logic              out_rden;
  logic [3*DW-1:0]   in_pos;
  logic [3*DW-1:0]   in_disp;
  logic              motion_update_enable;
  logic [3*DW-1:0]   out_data;
  logic [3*CIW-1:0]  out_data_dst_cell;
  logic              out_data_valid;
  logic              out_busy;
  logic              out_done;
  logic              out_error;

  motion_update_broadcaster #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .CELL_ID_WIDTH(CIW),
    .CELL_NUM_X(NX), .CELL_NUM_Y(NY), .CELL_NUM_Z(NZ)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .out_rd_cell(out_rd_cell), .out_rd_address(out_rd_address), .out_rden(out_rden),
    .in_pos(in_pos), .in_disp(in_disp),
    .motion_update_enable(motion_update_enable),
    .out_data(out_data), .out_data_dst_cell(out_data_dst_cell),
    .out_data_valid(out_data_valid), .out_busy(out_busy),
    .out_done(out_done), .out_error(out_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // ---------------- cell memory model ----------------
  logic [3*DW-1:0] mem_pos  [NCELL][MAXA];
  logic [3*DW-1:0] mem_disp [NCELL][MAXA];
  int              cnt      [NCELL];

  logic             req_rden = 1'b0;
  logic [3*CIW-1:0] req_cell;
  logic [AW-1:0]    req_addr;

  function automatic int cell_lin(logic [3*CIW-1:0] c);
    int x, y, z;
    x = int'(c[5:4]); y = int'(c[3:2]); z = int'(c[1:0]);
    if (x >= NX || y >= NY || z >= NZ) return -1;
    return x * NY * NZ + y * NZ + z;
  endfunction

  function automatic int dim_lim(int d);
    return (d == 0) ? NX : (d == 1) ? NY : NZ;
  endfunction

  always @(negedge clk) begin
    req_rden = out_rden;
    req_cell = out_rd_cell;
    req_addr = out_rd_address;
  end

  always @(posedge clk) begin
    int ci;
    #1;
    ci = cell_lin(req_cell);
    if (req_rden && ci >= 0 && int'(req_addr) < MAXA) begin
      in_pos  = mem_pos[ci][req_addr];
      in_disp = mem_disp[ci][req_addr];
    end else begin
      in_pos  = {$urandom, $urandom, $urandom};
      in_disp = {$urandom, $urandom, $urandom};
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < NCELL; i++) begin
      cnt[i] = 0;
      for (int a = 0; a < MAXA; a++) begin
        mem_pos[i][a]  = '0;
        mem_disp[i][a] = '0;
      end
    end
  endtask

  // Count word: count in the low AW bits, junk above it.
  task automatic finalize_counts();
    logic [3*DW-1:0] w;
    for (int i = 0; i < NCELL; i++) begin
      w = {$urandom, $urandom, $urandom};
      w[AW-1:0] = AW'(cnt[i]);
      mem_pos[i][0]  = w;
      mem_disp[i][0] = {$urandom, $urandom, $urandom};
    end
  endtask

  // ---------------- reference schedule ----------------
  logic            exp_valid [MAXC];
  logic [3*DW-1:0] exp_data  [MAXC];
  logic [3*CIW-1:0] exp_dst  [MAXC];
  logic            exp_en    [MAXC];
  logic            exp_busy  [MAXC];
  logic            exp_done  [MAXC];
  logic            exp_rden  [MAXC];
  logic [AW-1:0]   exp_addr  [MAXC];
  logic [3*CIW-1:0] exp_cell [MAXC];
  int              err_from;
  int              end_cycle;

  // Each cell costs READ_COUNT + WAIT_COUNT + count STREAM cycles + NEXT_CELL.
  // Address k of a cell starting at cycle cs is issued at cs+1+k, and its
  // broadcast appears two cycles later.
  task automatic build_schedule();
    int c, cs, i, dd;
    logic [DW-1:0] n;
    logic [1:0] ix [3];
    logic [3*DW-1:0] nd;
    bit ok;
    for (int t = 0; t < MAXC; t++) begin
      exp_valid[t] = 0; exp_data[t] = '0; exp_dst[t] = '0; exp_en[t] = 0;
      exp_busy[t] = 0; exp_done[t] = 0; exp_rden[t] = 0; exp_addr[t] = '0; exp_cell[t] = '0;
    end
    err_from = MAXC;
    c = 1;
    for (int x = 0; x < NX; x++)
      for (int y = 0; y < NY; y++)
        for (int z = 0; z < NZ; z++) begin
          i = x * NY * NZ + y * NZ + z;
          cs = c;
          exp_rden[cs] = 1; exp_addr[cs] = '0; exp_cell[cs] = {2'(x), 2'(y), 2'(z)};
          for (int k = 1; k <= cnt[i]; k++) begin
            exp_rden[cs+1+k] = 1;
            exp_addr[cs+1+k] = AW'(k);
            exp_cell[cs+1+k] = {2'(x), 2'(y), 2'(z)};
            ok = 1;
            for (int d = 0; d < 3; d++) begin
              n = mem_pos[i][k][d*DW +: DW] + mem_disp[i][k][d*DW +: DW];
              nd[d*DW +: DW] = n;
              ix[d] = n[DW-1:DW-2];
              if (int'(ix[d]) >= dim_lim(d)) ok = 0;
            end
            dd = cs + 3 + k;
            if (ok) begin
              exp_valid[dd] = 1;
              exp_data[dd]  = nd;
              exp_dst[dd]   = {ix[0], ix[1], ix[2]};
            end else if (dd < err_from) begin
              err_from = dd;
            end
          end
          c = cs + 3 + cnt[i];
        end
    // c is now the DRAIN cycle
    for (int t = 1; t <= c; t++) exp_en[t] = 1;
    for (int t = 1; t <= c + 3; t++) exp_busy[t] = 1;
    exp_done[c+4] = 1;
    end_cycle = c + 6;
  endtask

  task automatic chk(string name, int cyc, logic [127:0] act, logic [127:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, req);
    end
  endtask

  // Observations from the most recent pass
  int              first_valid_cycle, n_valid, done_cycle, en_fall_cycle;
  logic [3*DW-1:0] first_data;
  logic [3*CIW-1:0] first_dst;
  logic            final_err;

  // Called just after a rising edge; the start pulse occupies cycle 0.
  task automatic run_pass(string tag, int spur);
    build_schedule();
    first_valid_cycle = -1; n_valid = 0; done_cycle = -1; en_fall_cycle = -1;
    first_data = '0; first_dst = '0;
    start = 1'b1;
    for (int c = 0; c <= end_cycle; c++) begin
      @(negedge clk);
      chk("valid",  c, 128'(out_data_valid),       128'(exp_valid[c]));
      chk("data",   c, 128'(out_data),             128'(exp_data[c]));
      chk("dst",    c, 128'(out_data_dst_cell),    128'(exp_dst[c]));
      chk("enable", c, 128'(motion_update_enable), 128'(exp_en[c]));
      chk("busy",   c, 128'(out_busy),             128'(exp_busy[c]));
      chk("done",   c, 128'(out_done),             128'(exp_done[c]));
      chk("rden",   c, 128'(out_rden),             128'(exp_rden[c]));
      if (exp_rden[c]) begin
        chk("rd_addr", c, 128'(out_rd_address), 128'(exp_addr[c]));
        chk("rd_cell", c, 128'(out_rd_cell),    128'(exp_cell[c]));
      end
      if (c >= 1) chk("error", c, 128'(out_error), 128'(err_from <= c));
      if (out_data_valid === 1'b1) begin
        if (first_valid_cycle < 0) begin
          first_valid_cycle = c; first_data = out_data; first_dst = out_data_dst_cell;
        end
        n_valid++;
      end
      if (out_done === 1'b1 && done_cycle < 0) done_cycle = c;
      if (c >= 2 && motion_update_enable === 1'b0 && en_fall_cycle < 0) en_fall_cycle = c;
      @(posedge clk);
      #1;
      start = (c + 1 == spur);
    end
    final_err = out_error;
    $display("pass %s: cells=%0d end_cycle=%0d valids=%0d first_valid=%0d done=%0d err=%0b",
             tag, NCELL, end_cycle, n_valid, first_valid_cycle, done_cycle, final_err);
  endtask

  // ---------------- directed single-particle vectors ----------------
  typedef struct {
    logic [DW-1:0]    px, py, pz, dx, dy, dz;
    logic             exp_valid;
    logic [3*DW-1:0]  exp_data;
    logic [3*CIW-1:0] exp_dst;
  } vec_t;

  vec_t vt [6];

  initial begin
    logic [1:0] ib;
    // cell boundary crossing on x
    vt[0] = '{32'h3FFF_FFFF, 32'h0000_1000, 32'h0000_2000, 32'h1, 32'h0, 32'h0,
              1'b1, {32'h0000_2000, 32'h0000_1000, 32'h4000_0000}, 6'h10};
    // x wraps modulo 2^32; y/z land in index 1
    vt[1] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h0000_0000, 32'h2, 32'h0, 32'h4000_0000,
              1'b1, {32'h4000_0000, 32'h7FFF_FFFF, 32'h0000_0001}, 6'h05};
    // x index 3 with only 3 cells in x
    vt[2] = '{32'hC000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, '0, '0};
    // y index 2 with only 2 cells in y
    vt[3] = '{32'h0, 32'h8000_0000, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0, '0, '0};
    // highest legal x index, z crossing upward
    vt[4] = '{32'h8000_0000, 32'h0, 32'h3FFF_0000, 32'h1234, 32'h0, 32'h0001_0000,
              1'b1, {32'h4000_0000, 32'h0000_0000, 32'h8000_1234}, 6'h21};
    // negative displacements (two's complement) crossing downward on x
    vt[5] = '{32'h4000_0000, 32'h4000_0005, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB, 32'h0,
              1'b1, {32'h0000_0000, 32'h4000_0000, 32'h3FFF_FFFF}, 6'h04};

    rst = 1'b1; start = 1'b0;
    in_pos = '0; in_disp = '0;
    clear_mem(); finalize_counts();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_rden",   0, 128'(out_rden), 128'(0));
    chk("rst_addr",   0, 128'(out_rd_address), 128'(0));
    chk("rst_cell",   0, 128'(out_rd_cell), 128'(0));
    chk("rst_enable", 0, 128'(motion_update_enable), 128'(0));
    chk("rst_valid",  0, 128'(out_data_valid), 128'(0));
    chk("rst_data",   0, 128'(out_data), 128'(0));
    chk("rst_busy",   0, 128'(out_busy), 128'(0));
    chk("rst_done",   0, 128'(out_done), 128'(0));
    chk("rst_error",  0, 128'(out_error), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;

    // All cells empty, with a spurious start while busy
    clear_mem(); finalize_counts();
    run_pass("empty", 7);
    chk("empty_nvalid",  0, 128'(n_valid), 128'(0));
    chk("empty_en_fall", 0, 128'(en_fall_cycle), 128'(1 + 3 * NCELL + 1));
    chk("empty_done",    0, 128'(done_cycle), 128'(1 + 3 * NCELL + 4));

    // Cell (0,0,0) with three stationary particles
    clear_mem();
    cnt[0] = 3;
    for (int k = 1; k <= 3; k++) begin
      mem_pos[0][k]  = {32'(k * 7), 32'(k * 5), 32'(k * 3)};
      mem_disp[0][k] = '0;
    end
    finalize_counts();
    run_pass("three", 0);
    chk("three_first",  0, 128'(first_valid_cycle), 128'(5));
    chk("three_nvalid", 0, 128'(n_valid), 128'(3));
    chk("three_data",   0, 128'(first_data), 128'({32'd7, 32'd5, 32'd3}));
    chk("three_dst",    0, 128'(first_dst), 128'(0));

    // Table-driven single particle in cell (1,0,0)
    for (int r = 0; r < 6; r++) begin
      clear_mem();
      cnt[4] = 1;
      mem_pos[4][1]  = {vt[r].pz, vt[r].py, vt[r].px};
      mem_disp[4][1] = {vt[r].dz, vt[r].dy, vt[r].dx};
      finalize_counts();
      run_pass($sformatf("vec%0d", r), 0);
      chk("vec_nvalid", r, 128'(n_valid), 128'(vt[r].exp_valid ? 1 : 0));
      chk("vec_error",  r, 128'(final_err), 128'(!vt[r].exp_valid));
      if (vt[r].exp_valid) begin
        chk("vec_data", r, 128'(first_data), 128'(vt[r].exp_data));
        chk("vec_dst",  r, 128'(first_dst),  128'(vt[r].exp_dst));
      end
    end

    // Reset in the middle of STREAM
    clear_mem();
    cnt[0] = 5;
    for (int k = 1; k <= 5; k++) begin
      mem_pos[0][k]  = {32'(k), 32'(k * 2), 32'(k * 3)};
      mem_disp[0][k] = {32'(1), 32'(1), 32'(1)};
    end
    finalize_counts();
    start = 1'b1;
    @(posedge clk); #1; start = 1'b0;
    repeat (5) @(posedge clk);
    #2;
    chk("mid_valid_pre",  6, 128'(out_data_valid), 128'(1));
    chk("mid_enable_pre", 6, 128'(motion_update_enable), 128'(1));
    rst = 1'b1;
    #1;
    chk("mid_enable", 6, 128'(motion_update_enable), 128'(0));
    chk("mid_valid",  6, 128'(out_data_valid), 128'(0));
    chk("mid_data",   6, 128'(out_data), 128'(0));
    chk("mid_dst",    6, 128'(out_data_dst_cell), 128'(0));
    chk("mid_busy",   6, 128'(out_busy), 128'(0));
    chk("mid_rden",   6, 128'(out_rden), 128'(0));
    chk("mid_cell",   6, 128'(out_rd_cell), 128'(0));
    @(posedge clk); #1; rst = 1'b0;
    @(posedge clk); #1;
    run_pass("after_rst", 0);
    chk("after_rst_nvalid", 0, 128'(n_valid), 128'(5));

    // Randomized passes
    for (int p = 0; p < 4; p++) begin
      clear_mem();
      for (int i = 0; i < NCELL; i++) begin
        cnt[i] = $urandom_range(0, 4);
        for (int k = 1; k <= cnt[i]; k++) begin
          for (int d = 0; d < 3; d++) begin
            ib = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, dim_lim(d) - 1));
            mem_pos[i][k][d*DW +: DW]  = {ib, 30'($urandom)};
            mem_disp[i][k][d*DW +: DW] = 32'(int'($urandom_range(0, 2047)) - 1024);
          end
        end
      end
      finalize_counts();
      run_pass($sformatf("rand%0d", p), (p == 1) ? 9 : 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
